// File: rtl/motor_ctrl_pkg.sv
// motor_ctrl_pkg: shared widths, FSM state type and saturation helpers for the
// motor control path (speed PID and its multiply-accumulate unit).
package motor_ctrl_pkg;

    localparam int FRAC_BITS = 8;
    localparam int ERR_W     = 18;
    localparam int GAIN_W    = 16;
    localparam int ACC_W     = 51;
    localparam int MUL_A_W   = GAIN_W + 1;
    localparam int MUL_B_W   = 32;
    localparam int INTEG_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        MUL_P,
        MUL_I,
        MUL_D,
        SUM
    } pid_state_t;

    // Saturate a 33-bit signed difference to the 18-bit signed error range.
    function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [32:0] v);
        if (v > 33'sd131071) begin
            return 18'sh1ffff;
        end else if (v < -33'sd131072) begin
            return 18'sh20000;
        end else begin
            return $signed(v[ERR_W-1:0]);
        end
    endfunction

    // Clamp a one-bit-wider integrator sum to +/-lim.
    function automatic logic signed [INTEG_W-1:0] clamp_integ(
        input logic signed [INTEG_W:0] v,
        input logic signed [INTEG_W:0] lim
    );
        logic signed [INTEG_W:0] neg_lim;
        neg_lim = -lim;
        if (v > lim) begin
            return $signed(lim[INTEG_W-1:0]);
        end else if (v < neg_lim) begin
            return $signed(neg_lim[INTEG_W-1:0]);
        end else begin
            return $signed(v[INTEG_W-1:0]);
        end
    endfunction

endpackage

// File: rtl/pid_mac.sv
// pid_mac: shared signed 17x32 multiplier feeding a 51-bit accumulator register.
// Ports:
//   clock, reset      system clock, synchronous active-low reset
//   clear             zero the accumulator on the next edge
//   accumulate        add a*b into the accumulator on the next edge
//   a, b              signed multiplier operands
//   acc               accumulator value
module pid_mac
    import motor_ctrl_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       accumulate,
    input  logic signed [MUL_A_W-1:0]  a,
    input  logic signed [MUL_B_W-1:0]  b,
    output logic signed [ACC_W-1:0]    acc
);

    localparam int PROD_W = MUL_A_W + MUL_B_W;

    logic signed [PROD_W-1:0] product;

    assign product = PROD_W'(a) * PROD_W'(b);

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            acc <= '0;
        end else if (accumulate) begin
            acc <= acc + ACC_W'(product);
        end
    end

endmodule

// File: rtl/pid_speed_ctrl.sv
// pid_speed_ctrl: one PID update per measurement window, driving the PWM duty.
// Ports:
//   clock, reset      system clock, synchronous active-low reset
//   enable            0 clears loop state, duty and the period counter
//   setpoint, rpm_in  unsigned target and measured speed
//   kp, ki, kd        unsigned Q8.8 gains
//   duty, duty_valid  clamped duty word and its one-cycle update strobe
//   busy              high while an update is in progress
//
// state | meaning
// IDLE  | waiting for the period tick
// ERR   | error, derivative and integrator update; accumulator cleared
// MUL_P | acc += kp * e
// MUL_I | acc += ki * integ
// MUL_D | acc += kd * d
// SUM   | scale, clamp and register duty
module pid_speed_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int UPDATE_PERIOD = 100000002,
    parameter int DUTY_WIDTH    = 8,
    parameter int INT_LIMIT     = 1048576
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [31:0]           setpoint,
    input  logic [31:0]           rpm_in,
    input  logic [GAIN_W-1:0]     kp,
    input  logic [GAIN_W-1:0]     ki,
    input  logic [GAIN_W-1:0]     kd,
    output logic [DUTY_WIDTH-1:0] duty,
    output logic                  duty_valid,
    output logic                  busy
);

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(UPDATE_PERIOD - 1);
    localparam logic signed [INTEG_W:0] INT_LIM = (INTEG_W+1)'(INT_LIMIT);
    localparam logic signed [ACC_W-1:0] DUTY_MAX = ACC_W'(2**DUTY_WIDTH - 1);

    pid_state_t state, state_next;

    logic [CNT_W-1:0]          count;
    logic                      tick;
    logic [31:0]               sp_q, rpm_q;
    logic [GAIN_W-1:0]         kp_q, ki_q, kd_q;
    logic signed [ERR_W-1:0]   e_prev;
    logic signed [ERR_W:0]     d_q;
    logic signed [INTEG_W-1:0] integ;
    logic                      sat_hi, sat_lo;

    logic signed [32:0]        e_wide;
    logic signed [ERR_W-1:0]   e_new;
    logic signed [ERR_W:0]     d_new;
    logic signed [INTEG_W:0]   integ_sum;
    logic signed [INTEG_W-1:0] integ_new;
    logic                      hold_integ;

    logic                      mac_clear, mac_acc;
    logic signed [MUL_A_W-1:0] mul_a;
    logic signed [MUL_B_W-1:0] mul_b;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_sh;
    logic [DUTY_WIDTH-1:0]     duty_new;
    logic                      clip_hi, clip_lo;

    assign tick = (count == TICK_CNT);
    assign busy = (state != IDLE);

    // After ERR, e_prev already holds this update's error, so MUL_P reads it.
    assign e_wide    = $signed({1'b0, sp_q}) - $signed({1'b0, rpm_q});
    assign e_new     = sat_err(e_wide);
    assign d_new     = (ERR_W+1)'(e_new) - (ERR_W+1)'(e_prev);
    assign integ_sum = (INTEG_W+1)'(integ) + (INTEG_W+1)'(e_new);
    assign integ_new = clamp_integ(integ_sum, INT_LIM);
    assign hold_integ = (sat_hi && !e_new[ERR_W-1] && (e_new != '0))
                     || (sat_lo && e_new[ERR_W-1]);

    always_ff @(posedge clock) begin
        if (!reset || !enable) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mac_clear  = 1'b0;
        mac_acc    = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        case (state)
            IDLE:  if (tick) state_next = ERR;
            ERR: begin
                mac_clear  = 1'b1;
                state_next = MUL_P;
            end
            MUL_P: begin
                mac_acc    = 1'b1;
                mul_a      = $signed({1'b0, kp_q});
                mul_b      = MUL_B_W'(e_prev);
                state_next = MUL_I;
            end
            MUL_I: begin
                mac_acc    = 1'b1;
                mul_a      = $signed({1'b0, ki_q});
                mul_b      = MUL_B_W'(integ);
                state_next = MUL_D;
            end
            MUL_D: begin
                mac_acc    = 1'b1;
                mul_a      = $signed({1'b0, kd_q});
                mul_b      = MUL_B_W'(d_q);
                state_next = SUM;
            end
            SUM:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    pid_mac u_mac (
        .clock      (clock),
        .reset      (reset),
        .clear      (mac_clear),
        .accumulate (mac_acc),
        .a          (mul_a),
        .b          (mul_b),
        .acc        (acc)
    );

    assign acc_sh = acc >>> FRAC_BITS;

    always_comb begin
        duty_new = acc_sh[DUTY_WIDTH-1:0];
        clip_hi  = 1'b0;
        clip_lo  = 1'b0;
        if (acc_sh[ACC_W-1]) begin
            duty_new = '0;
            clip_lo  = 1'b1;
        end else if (acc_sh > DUTY_MAX) begin
            duty_new = '1;
            clip_hi  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || !enable) begin
            count      <= '0;
            sp_q       <= '0;
            rpm_q      <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            kd_q       <= '0;
            e_prev     <= '0;
            d_q        <= '0;
            integ      <= '0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
            duty       <= '0;
            duty_valid <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (tick) begin
                count <= '0;
                sp_q  <= setpoint;
                rpm_q <= rpm_in;
                kp_q  <= kp;
                ki_q  <= ki;
                kd_q  <= kd;
            end else begin
                count <= count + CNT_W'(1);
            end
            if (state == ERR) begin
                e_prev <= e_new;
                d_q    <= d_new;
                if (!hold_integ) begin
                    integ <= integ_new;
                end
            end
            if (state == SUM) begin
                duty       <= duty_new;
                duty_valid <= 1'b1;
                sat_hi     <= clip_hi;
                sat_lo     <= clip_lo;
            end
        end
    end

endmodule

// File: tb/tb_pid_speed_ctrl.sv
// tb_pid_speed_ctrl: directed and randomized updates compared against an
// integer-arithmetic model of the PID update rules.
module tb_pid_speed_ctrl;

    localparam int P     = 20;
    localparam int LIMIT = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] setpoint, rpm_in;
    logic [15:0] kp, ki, kd;
    logic [7:0]  duty;
    logic        duty_valid, busy;

    int n_checks = 0;
    int n_errors = 0;
    int next_lat;

    longint m_integ, m_eprev;
    bit     m_sathi, m_satlo;

    pid_speed_ctrl #(
        .UPDATE_PERIOD (P),
        .DUTY_WIDTH    (8),
        .INT_LIMIT     (1048576)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .setpoint   (setpoint),
        .rpm_in     (rpm_in),
        .kp         (kp),
        .ki         (ki),
        .kd         (kd),
        .duty       (duty),
        .duty_valid (duty_valid),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint got, input longint want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic model_clear();
        m_integ = 0;
        m_eprev = 0;
        m_sathi = 0;
        m_satlo = 0;
    endtask

    function automatic longint model_update(input longint sp, input longint rpm,
                                            input longint gp, input longint gi,
                                            input longint gd);
        longint e, d, acc, q;
        e = sp - rpm;
        if (e > 131071) e = 131071;
        if (e < -131072) e = -131072;
        d = e - m_eprev;
        if (!((m_sathi && e > 0) || (m_satlo && e < 0))) begin
            m_integ = m_integ + e;
            if (m_integ > 1048576) m_integ = 1048576;
            if (m_integ < -1048576) m_integ = -1048576;
        end
        m_eprev = e;
        acc = gp * e + gi * m_integ + gd * d;
        q = acc >>> 8;
        m_sathi = (q > 255);
        m_satlo = (q < 0);
        if (q > 255) q = 255;
        if (q < 0) q = 0;
        return q;
    endfunction

    task automatic wait_valid(input bit scramble, output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (n < LIMIT) begin
            @(negedge clock);
            n++;
            if (busy) begin
                nbusy++;
                if (scramble) begin
                    setpoint = $urandom;
                    rpm_in   = $urandom;
                    kp       = 16'($urandom);
                    ki       = 16'($urandom);
                    kd       = 16'($urandom);
                end
            end
            if (duty_valid) break;
        end
    endtask

    // Called at a negedge; leaves the bench one negedge after the strobe.
    task automatic run_update(input string tag, input longint sp, input longint rpm,
                              input longint gp, input longint gi, input longint gd,
                              input bit scramble);
        longint want;
        int n, nb;
        setpoint = sp[31:0];
        rpm_in   = rpm[31:0];
        kp       = gp[15:0];
        ki       = gi[15:0];
        kd       = gd[15:0];
        want = model_update(sp, rpm, gp, gi, gd);
        wait_valid(scramble, n, nb);
        chk({tag, "_lat"}, n, next_lat);
        chk({tag, "_busy"}, nb, 5);
        chk({tag, "_duty"}, duty, want);
        @(negedge clock);
        chk({tag, "_pulse"}, duty_valid, 0);
        chk({tag, "_hold"}, duty, want);
        next_lat = P - 1;
    endtask

    task automatic restart();
        enable = 1'b0;
        @(negedge clock);
        chk("off_duty", duty, 0);
        enable = 1'b1;
        model_clear();
        next_lat = P + 5;
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (!busy && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        chk("busy_seen", busy, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        longint sp, rpm;
        reset    = 1'b0;
        enable   = 1'b0;
        setpoint = '0;
        rpm_in   = '0;
        kp       = '0;
        ki       = '0;
        kd       = '0;
        model_clear();
        repeat (3) @(negedge clock);
        chk("rst_duty", duty, 0);
        chk("rst_valid", duty_valid, 0);
        chk("rst_busy", busy, 0);
        reset    = 1'b1;
        enable   = 1'b1;
        next_lat = P + 5;

        run_update("p_only", 100, 40, 256, 0, 0, 0);
        chk("p_only_60", duty, 60);
        run_update("sat_hi", 1000, 0, 256, 0, 0, 0);
        run_update("sat_lo", 1000, 1500, 256, 0, 0, 0);

        restart();
        for (int i = 0; i < 4; i++) run_update("integ", 110, 100, 0, 128, 0, 0);

        restart();
        for (int i = 0; i < 3; i++) run_update("aw_up", 300, 0, 0, 256, 0, 0);
        for (int i = 0; i < 6; i++) run_update("aw_dn", 0, 10, 0, 256, 0, 0);

        restart();
        run_update("deriv0", 100, 100, 0, 0, 256, 1);
        run_update("deriv1", 150, 100, 0, 0, 256, 1);
        run_update("deriv2", 150, 100, 0, 0, 256, 1);

        restart();
        for (int i = 0; i < 10; i++) run_update("iclamp_up", 64'hffffffff, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) run_update("iclamp_dn", 0, 64'hffffffff, 0, 0, 0, 0);
        run_update("iclamp_obs", 0, 100000, 0, 1, 0, 0);

        // Reset pulse while MUL_I is active.
        run_update("pre_rst", 100, 40, 256, 0, 0, 0);
        setpoint = 32'd110;
        rpm_in   = 32'd100;
        ki       = 16'h0080;
        wait_busy();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("rst_mid_duty", duty, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", duty_valid, 0);
        model_clear();
        next_lat = P + 5;
        run_update("post_rst", 110, 100, 0, 128, 0, 0);

        // Enable dropped while MUL_D is active.
        run_update("pre_en", 100, 40, 256, 0, 0, 0);
        setpoint = 32'd110;
        rpm_in   = 32'd100;
        kp       = 16'h0000;
        ki       = 16'h0080;
        wait_busy();
        repeat (3) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        chk("en_mid_duty", duty, 0);
        chk("en_mid_busy", busy, 0);
        chk("en_mid_valid", duty_valid, 0);
        enable = 1'b1;
        model_clear();
        next_lat = P + 5;
        run_update("post_en", 110, 100, 0, 128, 0, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                sp  = longint'($urandom);
                rpm = longint'($urandom);
            end else begin
                sp  = longint'($urandom_range(0, 1500));
                rpm = longint'($urandom_range(0, 1500));
            end
            run_update("rand", sp, rpm, longint'($urandom_range(0, 512)),
                       longint'($urandom_range(0, 64)), longint'($urandom_range(0, 512)), 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
